serial_fifo_bridge: RTL and testbench

SERIAL_FIFO_BRIDGE -- requirements
Module: serial_fifo_bridge

---
 rtl/serial_fifo_bridge_pkg.sv | 17 +
 rtl/byte_fifo.sv | 69 ++++++
 rtl/serial_fifo_bridge.sv | 103 ++++++++++
 tb/tb_serial_fifo_bridge.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_fifo_bridge_pkg.sv
// ============================================================================
// Module      : serial_fifo_bridge_pkg
// Description : Serial-IO constants shared by the FIFO bridge and the data
//               memory serial decode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_fifo_bridge_pkg;
    localparam int C_DEPTH         = 8;
    localparam int C_CW            = 4;
    localparam int C_ERR_W         = 2;
    localparam int C_ERR_UNDERFLOW = 0;
    localparam int C_ERR_OVERFLOW  = 1;
endpackage

`default_nettype wire

// File: rtl/byte_fifo.sv
// ============================================================================
// Module      : byte_fifo
// Description : Show-ahead byte FIFO; head byte is read combinationally
//               from registered storage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_fifo #(
    parameter int DEPTH = 8,
    parameter int CW    = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    localparam int C_AW = $clog2(DEPTH);

    logic [7:0]      r_mem [DEPTH];
    logic [C_AW-1:0] r_wr_ptr;
    logic [C_AW-1:0] r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            w_push;
    logic            w_pop;

    // Pop on empty is ignored; push on full is dropped even with a pop.
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + C_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign count = r_count;
    assign full  = (r_count == CW'(DEPTH));
    assign empty = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/serial_fifo_bridge.sv
// ============================================================================
// Module      : serial_fifo_bridge
// Description : Bridges processor serial strobes to host valid/ready streams
//               through an RX and a TX byte FIFO, with sticky error flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_fifo_bridge
    import serial_fifo_bridge_pkg::*;
#(
    parameter int DEPTH = C_DEPTH,
    parameter int CW    = C_CW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [7:0]    serial_in,
    input  logic          serial_wren_in,
    input  logic          serial_rden_in,
    output logic [7:0]    serial_out,
    output logic          serial_valid_out,
    output logic          serial_ready_out,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic          rx_ready,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic [CW-1:0] rx_count,
    output logic [CW-1:0] tx_count,
    output logic          err_underflow,
    output logic          err_overflow
);
    logic               w_rx_full;
    logic               w_rx_empty;
    logic               w_tx_full;
    logic               w_tx_empty;
    logic               w_rx_push;
    logic               w_rx_pop;
    logic               w_tx_push;
    logic               w_tx_pop;
    logic [C_ERR_W-1:0] r_err;

    // Readiness comes only from registered counts, never from same-cycle pops.
    assign rx_ready         = !w_rx_full;
    assign serial_ready_out = !w_tx_full;
    assign serial_valid_out = !w_rx_empty;
    assign tx_valid         = !w_tx_empty;

    assign w_rx_push = rx_valid && rx_ready;
    assign w_rx_pop  = serial_rden_in && serial_valid_out;
    assign w_tx_push = serial_wren_in && serial_ready_out;
    assign w_tx_pop  = tx_valid && tx_ready;

    byte_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_rx_fifo (
        .clock (clock),
        .reset (reset),
        .push  (w_rx_push),
        .pop   (w_rx_pop),
        .din   (rx_data),
        .dout  (serial_out),
        .count (rx_count),
        .full  (w_rx_full),
        .empty (w_rx_empty)
    );

    byte_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_tx_fifo (
        .clock (clock),
        .reset (reset),
        .push  (w_tx_push),
        .pop   (w_tx_pop),
        .din   (serial_in),
        .dout  (tx_data),
        .count (tx_count),
        .full  (w_tx_full),
        .empty (w_tx_empty)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_err <= '0;
        end else begin
            if (serial_rden_in && !serial_valid_out) begin
                r_err[C_ERR_UNDERFLOW] <= 1'b1;
            end
            if (serial_wren_in && !serial_ready_out) begin
                r_err[C_ERR_OVERFLOW] <= 1'b1;
            end
        end
    end

    assign err_underflow = r_err[C_ERR_UNDERFLOW];
    assign err_overflow  = r_err[C_ERR_OVERFLOW];

endmodule

`default_nettype wire

// File: tb/tb_serial_fifo_bridge.sv
// ============================================================================
// Module      : tb_serial_fifo_bridge
// Description : Directed vector table plus hand sequences for serial_fifo_bridge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_fifo_bridge;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] serial_in;
    logic       serial_wren_in;
    logic       serial_rden_in;
    logic [7:0] serial_out;
    logic       serial_valid_out;
    logic       serial_ready_out;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [3:0] rx_count;
    logic [3:0] tx_count;
    logic       err_underflow;
    logic       err_overflow;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_fifo_bridge #(
        .DEPTH (8),
        .CW    (4)
    ) dut (
        .clock            (clk),
        .reset            (rst),
        .serial_in        (serial_in),
        .serial_wren_in   (serial_wren_in),
        .serial_rden_in   (serial_rden_in),
        .serial_out       (serial_out),
        .serial_valid_out (serial_valid_out),
        .serial_ready_out (serial_ready_out),
        .rx_data          (rx_data),
        .rx_valid         (rx_valid),
        .rx_ready         (rx_ready),
        .tx_data          (tx_data),
        .tx_valid         (tx_valid),
        .tx_ready         (tx_ready),
        .rx_count         (rx_count),
        .tx_count         (tx_count),
        .err_underflow    (err_underflow),
        .err_overflow     (err_overflow)
    );

    typedef struct {
        logic       rxv;
        logic [7:0] rxd;
        logic       rd;
        logic       wr;
        logic [7:0] sin;
        logic       txr;
        logic [3:0] e_rxc;
        logic [3:0] e_txc;
        logic [7:0] e_sout;
        logic [7:0] e_tdata;
        logic [1:0] e_err;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rx_valid = 1'b0; rx_data = 8'h00; serial_rden_in = 1'b0;
        serial_wren_in = 1'b0; serial_in = 8'h00; tx_ready = 1'b0;
    endtask

    task automatic reset_dut();
        idle_inputs();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        //             rxv   rxd    rd    wr    sin    txr   rxc   txc   sout   tdata  err
        vecs[0]  = '{1'b1, 8'h41, 1'b0, 1'b0, 8'h00, 1'b0, 4'd1, 4'd0, 8'h41, 8'h00, 2'b00};
        vecs[1]  = '{1'b1, 8'h42, 1'b0, 1'b0, 8'h00, 1'b0, 4'd2, 4'd0, 8'h41, 8'h00, 2'b00};
        vecs[2]  = '{1'b1, 8'h43, 1'b0, 1'b0, 8'h00, 1'b0, 4'd3, 4'd0, 8'h41, 8'h00, 2'b00};
        vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 4'd2, 4'd0, 8'h42, 8'h00, 2'b00};
        vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 4'd1, 4'd0, 8'h43, 8'h00, 2'b00};
        vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 4'd0, 8'h00, 8'h00, 2'b00};
        vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h10, 1'b0, 4'd0, 4'd1, 8'h00, 8'h10, 2'b00};
        vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 1'b0, 4'd0, 4'd2, 8'h00, 8'h10, 2'b00};
        vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 4'd0, 4'd1, 8'h00, 8'h11, 2'b00};
        vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h12, 1'b1, 4'd0, 4'd1, 8'h00, 8'h12, 2'b00};
        vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 4'd0, 4'd0, 8'h00, 8'h00, 2'b00};
        vecs[11] = '{1'b1, 8'h7E, 1'b1, 1'b0, 8'h00, 1'b0, 4'd1, 4'd0, 8'h7E, 8'h00, 2'b01};
        vecs[12] = '{1'b1, 8'h55, 1'b1, 1'b0, 8'h00, 1'b0, 4'd1, 4'd0, 8'h55, 8'h00, 2'b01};
        vecs[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 4'd0, 8'h00, 8'h00, 2'b01};

        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rx_count", 32'(rx_count), 32'd0);
        chk("reset_tx_count", 32'(tx_count), 32'd0);
        chk("reset_valids", {serial_valid_out, tx_valid}, 2'b00);
        chk("reset_readies", {serial_ready_out, rx_ready}, 2'b11);
        chk("reset_errs", {err_overflow, err_underflow}, 2'b00);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            rx_valid = vecs[i].rxv; rx_data = vecs[i].rxd; serial_rden_in = vecs[i].rd;
            serial_wren_in = vecs[i].wr; serial_in = vecs[i].sin; tx_ready = vecs[i].txr;
            tick();
            chk($sformatf("vec%0d_rx_count", i), 32'(rx_count), 32'(vecs[i].e_rxc));
            chk($sformatf("vec%0d_tx_count", i), 32'(tx_count), 32'(vecs[i].e_txc));
            chk($sformatf("vec%0d_svalid", i), 32'(serial_valid_out), 32'(vecs[i].e_rxc != 0));
            chk($sformatf("vec%0d_tvalid", i), 32'(tx_valid), 32'(vecs[i].e_txc != 0));
            chk($sformatf("vec%0d_errs", i), {err_overflow, err_underflow}, vecs[i].e_err);
            if (vecs[i].e_rxc != 0) chk($sformatf("vec%0d_sout", i), 32'(serial_out), 32'(vecs[i].e_sout));
            if (vecs[i].e_txc != 0) chk($sformatf("vec%0d_tdata", i), 32'(tx_data), 32'(vecs[i].e_tdata));
        end
        idle_inputs();

        // RX backpressure: host holds the byte that was not accepted.
        begin
            logic [7:0] d;
            int model;
            reset_dut();
            d = 8'h20;
            model = 0;
            for (int i = 0; i < 10; i++) begin
                rx_valid = 1'b1;
                rx_data = d;
                chk($sformatf("bp_rx_ready_%0d", i), 32'(rx_ready), 32'(model < 8));
                tick();
                if (model < 8) begin
                    model++;
                    d++;
                end
            end
            rx_valid = 1'b0;
            chk("bp_rx_count_full", 32'(rx_count), 32'd8);
            chk("bp_rx_ready_low", 32'(rx_ready), 32'd0);
            for (int i = 0; i < 8; i++) begin
                chk($sformatf("bp_drain_%0d", i), 32'(serial_out), 32'(8'h20 + i));
                serial_rden_in = 1'b1;
                tick();
            end
            serial_rden_in = 1'b0;
            chk("bp_rx_empty", 32'(serial_valid_out), 32'd0);
            rx_valid = 1'b1;
            rx_data = d;
            tick();
            rx_valid = 1'b0;
            chk("bp_held_byte", 32'(serial_out), 32'h28);
            chk("bp_held_count", 32'(rx_count), 32'd1);
            chk("bp_no_errs", {err_overflow, err_underflow}, 2'b00);
        end

        // TX overflow and full-FIFO push+pop.
        reset_dut();
        for (int i = 0; i < 8; i++) begin
            serial_wren_in = 1'b1;
            serial_in = 8'(8'h80 + i);
            tick();
        end
        serial_wren_in = 1'b0;
        chk("ov_tx_full_count", 32'(tx_count), 32'd8);
        chk("ov_ready_low", 32'(serial_ready_out), 32'd0);
        chk("ov_err_before", 32'(err_overflow), 32'd0);
        serial_wren_in = 1'b1;
        serial_in = 8'h55;
        tick();
        serial_wren_in = 1'b0;
        chk("ov_err_set", 32'(err_overflow), 32'd1);
        chk("ov_count_held", 32'(tx_count), 32'd8);
        chk("ov_head", 32'(tx_data), 32'h80);
        serial_wren_in = 1'b1;
        serial_in = 8'h66;
        tx_ready = 1'b1;
        tick();
        serial_wren_in = 1'b0;
        tx_ready = 1'b0;
        chk("full_pushpop_count", 32'(tx_count), 32'd7);
        chk("full_pushpop_head", 32'(tx_data), 32'h81);
        for (int i = 1; i < 8; i++) begin
            chk($sformatf("ov_drain_%0d", i), 32'(tx_data), 32'(8'h80 + i));
            tx_ready = 1'b1;
            tick();
        end
        tx_ready = 1'b0;
        chk("ov_drained", {tx_valid, 4'(tx_count)}, 5'd0);
        chk("ov_err_sticky", 32'(err_overflow), 32'd1);

        // TX streaming at constant occupancy across pointer wrap.
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            serial_wren_in = 1'b1;
            serial_in = 8'(i);
            tick();
        end
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("st_head_%0d", i), 32'(tx_data), 32'(i));
            serial_wren_in = 1'b1;
            serial_in = 8'(4 + i);
            tx_ready = 1'b1;
            tick();
            chk($sformatf("st_count_%0d", i), 32'(tx_count), 32'd4);
        end
        idle_inputs();
        chk("st_head_end", 32'(tx_data), 32'd20);
        chk("st_no_errs", {err_overflow, err_underflow}, 2'b00);

        // Asynchronous reset mid-stream.
        reset_dut();
        serial_rden_in = 1'b1;
        tick();
        serial_rden_in = 1'b0;
        chk("ar_underflow_set", 32'(err_underflow), 32'd1);
        for (int i = 0; i < 5; i++) begin
            rx_valid = 1'b1;
            rx_data = 8'(8'h30 + i);
            serial_wren_in = (i < 3);
            serial_in = 8'(i);
            tick();
        end
        idle_inputs();
        chk("ar_rx_count", 32'(rx_count), 32'd5);
        chk("ar_tx_count", 32'(tx_count), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_counts_zero", {rx_count, tx_count}, 8'd0);
        chk("ar_valids_zero", {serial_valid_out, tx_valid}, 2'b00);
        chk("ar_readies_one", {serial_ready_out, rx_ready}, 2'b11);
        chk("ar_errs_zero", {err_overflow, err_underflow}, 2'b00);
        tick();
        @(negedge clk);
        rst = 1'b0;
        rx_valid = 1'b1;
        rx_data = 8'hA5;
        tick();
        rx_valid = 1'b0;
        chk("ar_first_push", 32'(serial_out), 32'hA5);
        chk("ar_first_count", 32'(rx_count), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
